// File: rtl/risc_spm.sv
// rtl/risc_spm.sv - 8-bit stored-program RISC machine with R0 mirrored on the user I/O pads.
// Multi-cycle controller, four registers, 256-byte unified memory loaded while held in reset.
module risc_spm #(
  parameter int MEM_DEPTH = 256
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       load_en,
  input  logic [7:0] load_addr,
  input  logic [7:0] load_data,
  output logic [7:0] io_out,
  output logic [7:0] io_oeb,
  output logic       halted
);

  typedef enum logic [3:0] {
    S_IDLE, S_FET1, S_FET2, S_DEC, S_EX1,
    S_RD1, S_RD2, S_WR1, S_WR2, S_BR1, S_BRZ1, S_HALT
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_NOT = 4'h4;
  localparam logic [3:0] OP_RD  = 4'h5;
  localparam logic [3:0] OP_WR  = 4'h6;
  localparam logic [3:0] OP_BR  = 4'h7;
  localparam logic [3:0] OP_BRZ = 4'h8;

  state_t      state, state_next;
  logic [7:0]  r [4];
  logic [7:0]  pc, ir, mar;
  logic        z;
  logic [7:0]  mem [MEM_DEPTH];

  logic [3:0]  op;
  logic [1:0]  src, dst;
  logic [7:0]  mem_rd;
  logic [7:0]  alu_y;

  logic ld_mar_pc, ld_mar_mem, ld_ir, inc_pc, ld_pc_mem, ld_alu, ld_rd, mem_we;

  assign op     = ir[7:4];
  assign src    = ir[3:2];
  assign dst    = ir[1:0];
  assign mem_rd = mem[mar];

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    ld_mar_pc  = 1'b0;
    ld_mar_mem = 1'b0;
    ld_ir      = 1'b0;
    inc_pc     = 1'b0;
    ld_pc_mem  = 1'b0;
    ld_alu     = 1'b0;
    ld_rd      = 1'b0;
    mem_we     = 1'b0;
    case (state)
      S_IDLE: state_next = S_FET1;
      S_FET1: begin
        ld_mar_pc  = 1'b1;
        state_next = S_FET2;
      end
      S_FET2: begin
        ld_ir      = 1'b1;
        inc_pc     = 1'b1;
        state_next = S_DEC;
      end
      S_DEC: begin
        case (op)
          OP_NOP: state_next = S_FET1;
          OP_ADD, OP_SUB, OP_AND, OP_NOT: state_next = S_EX1;
          OP_RD:  begin ld_mar_pc = 1'b1; state_next = S_RD1;  end
          OP_WR:  begin ld_mar_pc = 1'b1; state_next = S_WR1;  end
          OP_BR:  begin ld_mar_pc = 1'b1; state_next = S_BR1;  end
          OP_BRZ: begin ld_mar_pc = 1'b1; state_next = S_BRZ1; end
          default: state_next = S_HALT;
        endcase
      end
      S_EX1: begin
        ld_alu     = 1'b1;
        state_next = S_FET1;
      end
      // Address byte follows the opcode: point MAR at the operand, step past it.
      S_RD1: begin
        ld_mar_mem = 1'b1;
        inc_pc     = 1'b1;
        state_next = S_RD2;
      end
      S_WR1: begin
        ld_mar_mem = 1'b1;
        inc_pc     = 1'b1;
        state_next = S_WR2;
      end
      S_RD2: begin
        ld_rd      = 1'b1;
        state_next = S_FET1;
      end
      S_WR2: begin
        mem_we     = 1'b1;
        state_next = S_FET1;
      end
      S_BR1: begin
        ld_pc_mem  = 1'b1;
        state_next = S_FET1;
      end
      S_BRZ1: begin
        if (z) ld_pc_mem = 1'b1;
        else   inc_pc    = 1'b1;
        state_next = S_FET1;
      end
      S_HALT: state_next = S_HALT;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    alu_y = 8'h00;
    case (op)
      OP_ADD: alu_y = r[dst] + r[src];
      OP_SUB: alu_y = r[dst] - r[src];
      OP_AND: alu_y = r[dst] & r[src];
      OP_NOT: alu_y = ~r[src];
      default: alu_y = 8'h00;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < 4; i++) r[i] <= 8'h00;
      pc  <= 8'h00;
      ir  <= 8'h00;
      mar <= 8'h00;
      z   <= 1'b0;
    end else begin
      if (ld_mar_pc)       mar <= pc;
      else if (ld_mar_mem) mar <= mem_rd;
      if (ld_ir) ir <= mem_rd;
      if (ld_pc_mem)   pc <= mem_rd;
      else if (inc_pc) pc <= pc + 8'd1;
      if (ld_alu) begin
        r[dst] <= alu_y;
        z      <= (alu_y == 8'h00);
      end
      if (ld_rd) r[dst] <= mem_rd;
    end
  end

  // Memory is never cleared; reset only gates which port may write it.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      if (load_en) mem[load_addr] <= load_data;
    end else if (mem_we) begin
      mem[mar] <= r[src];
    end
  end

  assign io_out = r[0];
  assign io_oeb = 8'h00;
  assign halted = (state == S_HALT);

endmodule

// File: tb/tb_risc_spm.sv
// tb/tb_risc_spm.sv - scoreboard bench for risc_spm: expected R0 changes and halt events with cycle stamps.
module tb_risc_spm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load_en = 1'b0;
  logic [7:0] load_addr = 8'h00;
  logic [7:0] load_data = 8'h00;
  logic [7:0] io_out, io_oeb;
  logic       halted;

  risc_spm #(.MEM_DEPTH(256)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .load_en  (load_en),
    .load_addr(load_addr),
    .load_data(load_data),
    .io_out   (io_out),
    .io_oeb   (io_oeb),
    .halted   (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_halt;
    logic [7:0] val;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  logic [7:0] prev_io;
  logic       prev_halt;

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, req);
    end
  endtask

  task automatic exp_io(input logic [7:0] v, input int c);
    exp_t e;
    e.is_halt = 1'b0; e.val = v; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic exp_halt(input int c);
    exp_t e;
    e.is_halt = 1'b1; e.val = 8'h00; e.cyc = c;
    exp_q.push_back(e);
  endtask

  // Monitor: every R0 change or halt rise consumes the next expected event.
  always @(negedge clk) begin
    if (!rst) begin
      if (io_out !== prev_io) begin
        if (exp_q.size() == 0) chk("io_unexpected", io_out, prev_io);
        else begin
          mon_e = exp_q.pop_front();
          chk("event_kind_io", 0, int'(mon_e.is_halt));
          chk("io_value", io_out, mon_e.val);
          chk("io_cycle", cyc, mon_e.cyc);
        end
      end
      if (halted && !prev_halt) begin
        if (exp_q.size() == 0) chk("halt_unexpected", 1, 0);
        else begin
          mon_e = exp_q.pop_front();
          chk("event_kind_halt", 1, int'(mon_e.is_halt));
          chk("halt_cycle", cyc, mon_e.cyc);
        end
      end
    end
    prev_io   <= io_out;
    prev_halt <= halted;
  end

  task automatic ld(input logic [7:0] a, input logic [7:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic do_reset(input string nm);
    rst = 1'b1;
    @(negedge clk);
    chk({nm, "_rst_io"}, io_out, 8'h00);
    chk({nm, "_rst_halted"}, halted, 0);
  endtask

  task automatic run(input string nm, input int budget);
    rst = 1'b0;
    while (!halted && cyc < budget) @(negedge clk);
    repeat (2) @(negedge clk);
    chk({nm, "_halted"}, halted, 1);
    chk({nm, "_drained"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_io", io_out, 8'h00);
    chk("reset_halted", halted, 0);
    chk("io_oeb", io_oeb, 8'h00);

    // Reset and load: RD R0,[10]; HALT
    ld(8'h00, 8'h50); ld(8'h01, 8'h10); ld(8'h02, 8'hF0); ld(8'h10, 8'hA5);
    exp_io(8'hA5, 6); exp_halt(9);
    run("load", 200);

    // ADD 80+80 -> 0, Z=1, BRZ taken, NOT -> FF
    do_reset("alu");
    ld(8'h00, 8'h50); ld(8'h01, 8'h20); ld(8'h02, 8'h51); ld(8'h03, 8'h20);
    ld(8'h04, 8'h14); ld(8'h05, 8'h80); ld(8'h06, 8'h0A); ld(8'h07, 8'hF0);
    ld(8'h0A, 8'h40); ld(8'h0B, 8'hF0); ld(8'h20, 8'h80);
    exp_io(8'h80, 6); exp_io(8'h00, 15); exp_io(8'hFF, 23); exp_halt(26);
    run("alu", 200);

    // SUB 01-02 -> FF, Z=0, BRZ falls through to NOT -> 00
    do_reset("sub");
    ld(8'h00, 8'h50); ld(8'h01, 8'h20); ld(8'h02, 8'h51); ld(8'h03, 8'h21);
    ld(8'h04, 8'h24); ld(8'h05, 8'h80); ld(8'h06, 8'h0A); ld(8'h07, 8'h40);
    ld(8'h08, 8'hF0); ld(8'h0A, 8'hF0); ld(8'h20, 8'h01); ld(8'h21, 8'h02);
    exp_io(8'h01, 6); exp_io(8'hFF, 15); exp_io(8'h00, 23); exp_halt(26);
    run("sub", 200);

    // Loop: R0=5, R1=1; SUB; BRZ 09; BR 04; HALT
    do_reset("loop");
    ld(8'h00, 8'h50); ld(8'h01, 8'h20); ld(8'h02, 8'h51); ld(8'h03, 8'h21);
    ld(8'h04, 8'h24); ld(8'h05, 8'h80); ld(8'h06, 8'h09); ld(8'h07, 8'h70);
    ld(8'h08, 8'h04); ld(8'h09, 8'hF0); ld(8'h20, 8'h05); ld(8'h21, 8'h01);
    exp_io(8'h05, 6);
    for (int k = 0; k < 5; k++) exp_io(8'(4 - k), 15 + 12 * k);
    exp_halt(70);
    run("loop", 300);

    // Write-back: RD R2; WR R2->[40]; RD R0<-[40]
    do_reset("wb");
    ld(8'h00, 8'h52); ld(8'h01, 8'h20); ld(8'h02, 8'h68); ld(8'h03, 8'h40);
    ld(8'h04, 8'h50); ld(8'h05, 8'h40); ld(8'h06, 8'hF0);
    ld(8'h20, 8'h3C); ld(8'h40, 8'h11);
    exp_io(8'h3C, 16); exp_halt(19);
    run("wb", 200);

    // Illegal opcode 0x9x halts at the decode edge
    do_reset("illegal");
    ld(8'h00, 8'h93); ld(8'h31, 8'h22);
    exp_halt(4);
    run("illegal", 200);
    // load_en with reset low must not write memory
    load_en = 1'b1; load_addr = 8'h31; load_data = 8'hEE;
    repeat (2) @(negedge clk);
    load_en = 1'b0;

    // Reset during S_WR2 aborts the write
    do_reset("wr2a");
    ld(8'h00, 8'h50); ld(8'h01, 8'h20); ld(8'h02, 8'h52); ld(8'h03, 8'h20);
    ld(8'h04, 8'h68); ld(8'h05, 8'h30); ld(8'h06, 8'hF0);
    ld(8'h20, 8'h77); ld(8'h30, 8'h5A);
    exp_io(8'h77, 6);
    rst = 1'b0;
    while (cyc < 15) @(negedge clk);
    do_reset("wr2_abort");
    chk("wr2_drained", exp_q.size(), 0);
    exp_q.delete();
    ld(8'h00, 8'h50); ld(8'h01, 8'h30); ld(8'h02, 8'h50); ld(8'h03, 8'h31);
    ld(8'h04, 8'hF0);
    exp_io(8'h5A, 6); exp_io(8'h22, 11); exp_halt(14);
    run("wr2b", 200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/risc_spm.md
# risc_spm

8-bit stored-program RISC machine (RISC-SPM) that sits in the Caravel user project area behind the management SoC. It has four general registers, a 256-byte unified program/data memory, a single-bus datapath and a multi-cycle controller. Register R0 drives the user I/O pads `mprj_io[7:0]`, so a running program is visible off-chip. Program memory is loaded through a byte-write port while the core is held in reset.

## Interface
Parameters:
- `MEM_DEPTH`, 256: memory size in bytes. Addresses are 8 bits wide.

Ports:
- `wb_clk_i`  in  1  single clock. All state updates on the rising edge.
- `wb_rst_i`  in  1  reset: synchronous, active-high.
- `load_en`  in  1  memory load strobe. Honoured only while `wb_rst_i`=1.
- `load_addr`  in  8  load address.
- `load_data`  in  8  load byte.
- `io_out`  out  8  current value of R0. Drives `mprj_io[7:0]`.
- `io_oeb`  out  8  pad output-enable bar. Constant 0 (all outputs).
- `halted`  out  1  high while the controller is in S_HALT.

## Operation
- State:
  - Registers R0..R3 (8b), PC (8b), IR (8b), MAR (8b), zero flag Z.
  - Memory `mem[256]` with combinational read at MAR and synchronous write.
- Instruction byte format: op=[7:4], src=[3:2], dst=[1:0].
- Two-byte instructions (RD, WR, BR, BRZ) carry their address in the following byte.
- Opcodes:
  - 0 NOP.
  - 1 ADD: dst←dst+src, modulo 256.
  - 2 SUB: dst←dst−src, modulo 256.
  - 3 AND: dst←dst&src.
  - 4 NOT: dst←~src.
  - 5 RD: dst←mem[addr].
  - 6 WR: mem[addr]←src.
  - 7 BR: PC←addr.
  - 8 BRZ: PC←addr if Z=1, else skip the address byte.
  - F HALT.
  - 9..E are illegal and behave as HALT.
- Z is updated only by ADD, SUB, AND and NOT: Z=1 when the 8-bit result is 0. Carry and borrow are discarded. All other instructions leave Z unchanged.
- src==dst is legal, e.g. SUB R1,R1 gives 0 and Z=1.
- FSM states and actions:
  - S_IDLE: next state is S_FET1.
  - S_FET1: MAR←PC.
  - S_FET2: IR←mem[MAR]; PC←PC+1.
  - S_DEC:
    - NOP returns to S_FET1.
    - ALU ops go to S_EX1.
    - RD, WR, BR and BRZ load MAR←PC, then go to S_RD1, S_WR1, S_BR1 or S_BRZ1 respectively.
    - HALT and illegal opcodes go to S_HALT.
  - S_EX1: write the ALU result and Z, then S_FET1.
  - S_RD1 and S_WR1: MAR←mem[MAR]; PC←PC+1.
  - S_RD2: dst←mem[MAR].
  - S_WR2: mem[MAR]←src. Both S_RD2 and S_WR2 return to S_FET1.
  - S_BR1: PC←mem[MAR], then S_FET1.
  - S_BRZ1: PC←mem[MAR] if Z=1, else PC←PC+1; then S_FET1.
  - S_HALT: absorbing state. Only reset leaves it.
- PC wraps from 0xFF to 0x00.
- A WR to address 0xFF in the middle of the program is legal and simply overwrites memory.

## Timing
- Reset (synchronous, active-high):
  - On the first clock edge with `wb_rst_i`=1: R0..R3=0, PC=0, IR=0, MAR=0, Z=0, state=S_IDLE.
  - Outputs during and after reset: `io_out`=0x00, `halted`=0.
  - Memory contents are not cleared by reset.
  - Reset asserted mid-instruction aborts that instruction on the next edge; a pending S_WR2 write does not occur.
- Loading: while reset is high and `load_en`=1, mem[`load_addr`]←`load_data` at each edge. `load_en` is ignored while reset is low.
- Cycles per instruction, counted from S_FET1:
  - NOP: 3.
  - ALU ops: 4.
  - BR and BRZ: 4.
  - RD and WR: 5.
  - The first S_FET1 occurs on the second edge after reset is released, because S_IDLE takes one cycle.
- `io_out` changes on the edge that writes R0, which is the S_EX1 or S_RD2 edge.
- `halted` rises on the edge that enters S_HALT.

## Test plan
- Reset and load: load 0x5_0 0x10 0xF0 at 0..2 and mem[0x10]=0xA5, then release reset.
  - `io_out`=0xA5 after 1+5 cycles.
  - `halted`=1 after 3 more cycles.
- ALU and Z: R0=0x80, R1=0x80 via RD.
  - ADD R1→R0 gives `io_out`=0x00 and Z=1.
  - A following BRZ branches to its target.
  - NOT R0→R0 then gives 0xFF.
- SUB wrap: R0=0x01, R1=0x02; SUB R1 from R0 → `io_out`=0xFF, Z=0, and BRZ falls through (PC skips the address byte).
- Loop counter: program decrements R0 from 5 via SUB/BRZ/BR.
  - `io_out` sequence is 04,03,02,01,00, then halt.
  - Total cycle count matches the per-instruction counts above.
- Memory write-back: WR R2→0x40, then RD 0x40→R0 → `io_out` equals R2.
- Illegal and reset edge cases:
  - Opcode 0x9x → `halted`=1 within 3 cycles of S_FET1.
  - Reset pulsed during S_WR2 → the target byte is unchanged, PC=0 and `io_out`=0.
